// File: rtl/decode_stage_p_if.sv
// Bundle of the decode-stage signals: IF/ID side inputs, writeback port,
// pipeline control and the registered ID/EX outputs.
interface decode_stage_p_if #(parameter int DWIDTH = 16);
  logic [15:0]       instr_in;
  logic              instr_valid;
  logic [1:0]        size;
  logic              zero_ex;
  logic [1:0]        reg_dst;
  logic              reg_write;
  logic              mem_read;
  logic              uses_rs;
  logic              uses_rt;
  logic              flush;
  logic              stall_in;
  logic              wb_en;
  logic [2:0]        wb_reg;
  logic [DWIDTH-1:0] wb_data;
  logic              stall_out;
  logic              ex_valid;
  logic [DWIDTH-1:0] ex_rd1;
  logic [DWIDTH-1:0] ex_rd2;
  logic [DWIDTH-1:0] ex_imm;
  logic [2:0]        ex_wreg;
  logic              ex_wen;
  logic              ex_mem_read;
  logic              ex_err;

  // Driver side (fetch, writeback and execute control)
  modport master (
    output instr_in, instr_valid, size, zero_ex, reg_dst, reg_write, mem_read,
           uses_rs, uses_rt, flush, stall_in, wb_en, wb_reg, wb_data,
    input  stall_out, ex_valid, ex_rd1, ex_rd2, ex_imm, ex_wreg, ex_wen,
           ex_mem_read, ex_err
  );

  // Decode stage side
  modport slave (
    input  instr_in, instr_valid, size, zero_ex, reg_dst, reg_write, mem_read,
           uses_rs, uses_rt, flush, stall_in, wb_en, wb_reg, wb_data,
    output stall_out, ex_valid, ex_rd1, ex_rd2, ex_imm, ex_wreg, ex_wen,
           ex_mem_read, ex_err
  );
endinterface

// File: rtl/decode_stage_p.sv
// Decode stage: immediate extension, destination select, 8-entry register
// file with optional write-through bypass, load-use bubble insertion and the
// ID/EX pipeline register with stall/flush handling.
module decode_stage_p #(
  parameter int DWIDTH = 16,
  parameter bit BYPASS = 1'b1
) (
  input logic             clk,
  input logic             rst,
  decode_stage_p_if.slave bus
);

  logic [DWIDTH-1:0] regs_r [8];
  logic [2:0]        rs_sel_s;
  logic [2:0]        rt_sel_s;
  logic [DWIDTH-1:0] rd1_s;
  logic [DWIDTH-1:0] rd2_s;
  logic [DWIDTH-1:0] imm_s;
  logic [2:0]        wreg_s;
  logic              err_s;
  logic              hazard_s;
  logic              unused_bits_s;

  logic              ex_valid_r;
  logic [DWIDTH-1:0] ex_rd1_r;
  logic [DWIDTH-1:0] ex_rd2_r;
  logic [DWIDTH-1:0] ex_imm_r;
  logic [2:0]        ex_wreg_r;
  logic              ex_wen_r;
  logic              ex_mem_read_r;
  logic              ex_err_r;

  // Extend the size-selected immediate field; the illegal size yields zero.
  function automatic logic [DWIDTH-1:0] ext_imm(input logic [15:0] instr,
                                                input logic [1:0]  size,
                                                input logic        zero_ex);
    logic [DWIDTH-1:0] imm;
    case (size)
      2'b00:   imm = {{(DWIDTH-5){instr[4] & ~zero_ex}}, instr[4:0]};
      2'b01:   imm = {{(DWIDTH-8){instr[7] & ~zero_ex}}, instr[7:0]};
      2'b10:   imm = {{(DWIDTH-11){instr[10] & ~zero_ex}}, instr[10:0]};
      default: imm = {DWIDTH{1'b0}};
    endcase
    return imm;
  endfunction

  assign rs_sel_s      = bus.instr_in[10:8];
  assign rt_sel_s      = bus.instr_in[7:5];
  assign unused_bits_s = ^bus.instr_in[15:11];

  // Register file write port; R0 is an ordinary register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_r[i] <= {DWIDTH{1'b0}};
    end else if (bus.wb_en) begin
      regs_r[bus.wb_reg] <= bus.wb_data;
    end
  end

  // Read ports, optionally returning same-cycle writeback data.
  always_comb begin
    rd1_s = regs_r[rs_sel_s];
    rd2_s = regs_r[rt_sel_s];
    if (BYPASS && bus.wb_en && (bus.wb_reg == rs_sel_s)) begin
      rd1_s = bus.wb_data;
    end else begin
      rd1_s = regs_r[rs_sel_s];
    end
    if (BYPASS && bus.wb_en && (bus.wb_reg == rt_sel_s)) begin
      rd2_s = bus.wb_data;
    end else begin
      rd2_s = regs_r[rt_sel_s];
    end
  end

  // Immediate, destination select, illegal-size flag and load-use hazard.
  always_comb begin
    imm_s = ext_imm(bus.instr_in, bus.size, bus.zero_ex);
    err_s = (bus.size == 2'b11) & bus.instr_valid;
    case (bus.reg_dst)
      2'b00:   wreg_s = bus.instr_in[7:5];
      2'b01:   wreg_s = bus.instr_in[4:2];
      2'b10:   wreg_s = bus.instr_in[10:8];
      default: wreg_s = 3'b111;
    endcase
    hazard_s = bus.instr_valid & ex_valid_r & ex_mem_read_r & ex_wen_r &
               ((bus.uses_rs & (ex_wreg_r == rs_sel_s)) |
                (bus.uses_rt & (ex_wreg_r == rt_sel_s)));
  end

  // ID/EX register: reset, flush, stall hold, bubble, then normal load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r    <= 1'b0;
      ex_rd1_r      <= {DWIDTH{1'b0}};
      ex_rd2_r      <= {DWIDTH{1'b0}};
      ex_imm_r      <= {DWIDTH{1'b0}};
      ex_wreg_r     <= 3'b000;
      ex_wen_r      <= 1'b0;
      ex_mem_read_r <= 1'b0;
      ex_err_r      <= 1'b0;
    end else if (bus.flush || (!bus.stall_in && hazard_s)) begin
      ex_valid_r    <= 1'b0;
      ex_wen_r      <= 1'b0;
      ex_mem_read_r <= 1'b0;
      ex_err_r      <= 1'b0;
    end else if (!bus.stall_in) begin
      ex_valid_r    <= bus.instr_valid;
      ex_rd1_r      <= rd1_s;
      ex_rd2_r      <= rd2_s;
      ex_imm_r      <= imm_s;
      ex_wreg_r     <= wreg_s;
      ex_wen_r      <= bus.reg_write & bus.instr_valid;
      ex_mem_read_r <= bus.mem_read & bus.instr_valid;
      ex_err_r      <= err_s;
    end
  end

  assign bus.stall_out   = bus.stall_in | hazard_s;
  assign bus.ex_valid    = ex_valid_r;
  assign bus.ex_rd1      = ex_rd1_r;
  assign bus.ex_rd2      = ex_rd2_r;
  assign bus.ex_imm      = ex_imm_r;
  assign bus.ex_wreg     = ex_wreg_r;
  assign bus.ex_wen      = ex_wen_r;
  assign bus.ex_mem_read = ex_mem_read_r;
  assign bus.ex_err      = ex_err_r;

endmodule
